// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage encodings: ALU function codes, jXX/cmovXX
// condition codes and condition-code bit positions.
package y86_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Field order matches the {ZF,SF,OF} port packing.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/alu_cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a {ZF,SF,OF} triple.
// Codes above C_G are reported as bad and evaluate false.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] flags_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o,
  output logic       bad_ifun_o
);

  logic zf, sf, of, lt;

  assign zf = flags_i[CC_ZF];
  assign sf = flags_i[CC_SF];
  assign of = flags_i[CC_OF];
  assign lt = sf ^ of;

  always_comb begin
    cnd_o      = 1'b0;
    bad_ifun_o = 1'b0;
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = lt | zf;
      C_L:     cnd_o = lt;
      C_E:     cnd_o = zf;
      C_NE:    cnd_o = ~zf;
      C_GE:    cnd_o = ~lt;
      C_G:     cnd_o = ~lt & ~zf;
      default: bad_ifun_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cc_unit.sv
// Execute-stage ALU consumer: result select, flag derivation, CC register,
// valE register and condition evaluation. Optional macro: CC_FORWARD_EN.
module alu_cc_unit
  import y86_pkg::*;
#(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [1:0]   alu_fun,
  input  logic [W-1:0] add_out,
  input  logic [W-1:0] sub_out,
  input  logic [W-1:0] and_out,
  input  logic [W-1:0] xor_out,
  input  logic         add_ovf,
  input  logic         sub_ovf,
  input  logic         set_cc,
  input  logic [3:0]   ifun,
  input  logic         stall,
  input  logic         bubble,
  output logic [2:0]   cc,
  output logic         cnd,
  output logic [W-1:0] val_e,
  output logic         out_valid,
  output logic         cc_err
);

  cc_t          cc_q, cc_d;
  logic [W-1:0] val_e_q, val_e_d;
  logic         out_valid_q, out_valid_d;
  logic         cc_err_q, cc_err_d;

  logic [W-1:0] res;
  logic         ovf;
  cc_t          flags;
  logic         cnd_r, bad_r, bad_ifun;

  // Unselected buses are not guaranteed zero, so this must be a true mux.
  always_comb begin
    res = add_out;
    ovf = add_ovf;
    case (alu_fun)
      ALU_ADD: begin res = add_out; ovf = add_ovf; end
      ALU_SUB: begin res = sub_out; ovf = sub_ovf; end
      ALU_AND: begin res = and_out; ovf = 1'b0;    end
      ALU_XOR: begin res = xor_out; ovf = 1'b0;    end
      default: begin res = add_out; ovf = add_ovf; end
    endcase
  end

  always_comb begin
    flags.zf = (res == '0);
    flags.sf = res[W-1];
    flags.of = ovf;
  end

  cond_eval u_cond_reg (
    .flags_i    (cc_q),
    .ifun_i     (ifun),
    .cnd_o      (cnd_r),
    .bad_ifun_o (bad_r)
  );

`ifdef CC_FORWARD_EN
  logic cnd_f, bad_f, cc_wr;

  assign cc_wr = in_valid & set_cc & ~stall & ~bubble;

  cond_eval u_cond_fwd (
    .flags_i    (flags),
    .ifun_i     (ifun),
    .cnd_o      (cnd_f),
    .bad_ifun_o (bad_f)
  );

  assign cnd      = cc_wr ? cnd_f : cnd_r;
  assign bad_ifun = bad_r | bad_f;
`else
  assign cnd      = cnd_r;
  assign bad_ifun = bad_r;
`endif

  // Stall freezes everything; bubble kills the output slot and any CC write.
  always_comb begin
    cc_d        = cc_q;
    val_e_d     = val_e_q;
    out_valid_d = out_valid_q;
    cc_err_d    = cc_err_q;
    if (!stall) begin
      if (in_valid && bad_ifun) cc_err_d = 1'b1;
      if (bubble) begin
        out_valid_d = 1'b0;
        val_e_d     = '0;
      end else begin
        out_valid_d = in_valid;
        val_e_d     = in_valid ? res : '0;
        if (in_valid && set_cc) cc_d = flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q        <= cc_t'(CC_RST);
      val_e_q     <= '0;
      out_valid_q <= 1'b0;
      cc_err_q    <= 1'b0;
    end else begin
      cc_q        <= cc_d;
      val_e_q     <= val_e_d;
      out_valid_q <= out_valid_d;
      cc_err_q    <= cc_err_d;
    end
  end

  assign cc        = cc_q;
  assign val_e     = val_e_q;
  assign out_valid = out_valid_q;
  assign cc_err    = cc_err_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Self-checking bench for alu_cc_unit: directed scenarios then random traffic
// against a behavioural model of the CC/valE rules.
module tb_alu_cc_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, add_ovf, sub_ovf, set_cc, stall, bubble;
  logic [1:0]   alu_fun;
  logic [W-1:0] add_out, sub_out, and_out, xor_out;
  logic [3:0]   ifun;
  logic [2:0]   cc;
  logic         cnd, out_valid, cc_err;
  logic [W-1:0] val_e;

  always #5 clk = ~clk;

  alu_cc_unit #(.W(W), .CC_RST(3'b100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_fun(alu_fun),
    .add_out(add_out), .sub_out(sub_out), .and_out(and_out), .xor_out(xor_out),
    .add_ovf(add_ovf), .sub_ovf(sub_ovf), .set_cc(set_cc), .ifun(ifun),
    .stall(stall), .bubble(bubble), .cc(cc), .cnd(cnd), .val_e(val_e),
    .out_valid(out_valid), .cc_err(cc_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  logic [2:0]   m_cc;
  logic [W-1:0] m_val;
  logic         m_ov, m_err;
  logic         m_known = 1'b0;
  logic [W-1:0] m_res;
  logic [2:0]   m_flags;

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic cond_ref(input logic [2:0] f, input logic [3:0] fn);
    logic z, s, o;
    z = f[2]; s = f[1]; o = f[0];
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s != o) || z;
      4'd2:    return s != o;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return s == o;
      4'd6:    return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Real result on the selected bus, garbage on the others.
  task automatic drive_op(input logic [1:0] fun, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sc, input logic [3:0] fn);
    logic [W:0] sx;
    logic       of;
    in_valid = 1'b1; alu_fun = fun; set_cc = sc; ifun = fn;
    add_out = rnd64(); sub_out = rnd64(); and_out = rnd64(); xor_out = rnd64();
    add_ovf = 1'($urandom); sub_ovf = 1'($urandom);
    of = 1'b0;
    case (fun)
      2'd0: begin
        m_res = a + b; sx = {a[W-1], a} + {b[W-1], b};
        add_ovf = sx[W] ^ sx[W-1]; add_out = m_res; of = add_ovf;
      end
      2'd1: begin
        m_res = a - b; sx = {a[W-1], a} - {b[W-1], b};
        sub_ovf = sx[W] ^ sx[W-1]; sub_out = m_res; of = sub_ovf;
      end
      2'd2:    begin m_res = a & b; and_out = m_res; end
      default: begin m_res = a ^ b; xor_out = m_res; end
    endcase
    m_flags = {m_res == '0, m_res[W-1], of};
  endtask

  task automatic drive_idle(input logic [3:0] fn);
    in_valid = 1'b0; alu_fun = 2'($urandom); set_cc = 1'($urandom); ifun = fn;
    add_out = rnd64(); sub_out = rnd64(); and_out = rnd64(); xor_out = rnd64();
    add_ovf = 1'($urandom); sub_ovf = 1'($urandom);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    logic [2:0] cf;
    #1;
    cf = m_cc;
`ifdef CC_FORWARD_EN
    if (in_valid && set_cc && !stall && !bubble) cf = m_flags;
`endif
    if (m_known) chk("cnd", 64'(cnd), 64'(cond_ref(cf, ifun)));
    @(posedge clk);
    if (!rst_n) begin
      m_cc = 3'b100; m_val = '0; m_ov = 1'b0; m_err = 1'b0; m_known = 1'b1;
    end else if (!stall) begin
      if (in_valid && ifun > 4'd6) m_err = 1'b1;
      if (bubble) begin
        m_ov = 1'b0; m_val = '0;
      end else begin
        m_ov = in_valid; m_val = in_valid ? m_res : '0;
        if (in_valid && set_cc) m_cc = m_flags;
      end
    end
    @(negedge clk);
    if (m_known) begin
      chk("cc", 64'(cc), 64'(m_cc));
      chk("val_e", val_e, m_val);
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("cc_err", 64'(cc_err), 64'(m_err));
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [3:0]   fn;
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
    drive_idle(4'd3);
    m_res = '0; m_flags = '0;
    @(negedge clk);

    // Reset for two cycles
    cycle(); cycle();
    chk("rst_cc", 64'(cc), 64'(3'b100));
    chk("rst_val_e", val_e, 64'h0);
    chk("rst_cnd_e", 64'(cnd), 64'(1'b1));
    rst_n = 1'b1;

    // Signed overflow on add
    drive_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 4'd2); cycle();
    chk("t2_cc", 64'(cc), 64'(3'b011));
    chk("t2_val_e", val_e, 64'h8000_0000_0000_0000);
    drive_idle(4'd2); #1 chk("t2_cnd_l", 64'(cnd), 64'(1'b0)); cycle();
    drive_idle(4'd1); #1 chk("t2_cnd_le", 64'(cnd), 64'(1'b0)); cycle();

    // Zero result on sub
    drive_op(2'd1, 64'd5, 64'd5, 1'b1, 4'd3); cycle();
    chk("t3_cc", 64'(cc), 64'(3'b100));
    drive_idle(4'd3); #1 chk("t3_cnd_e", 64'(cnd), 64'(1'b1)); cycle();
    drive_idle(4'd4); #1 chk("t3_cnd_ne", 64'(cnd), 64'(1'b0)); cycle();
    drive_idle(4'd6); #1 chk("t3_cnd_g", 64'(cnd), 64'(1'b0)); cycle();

    // Stall then bubble with a CC-setting xor
    drive_op(2'd0, 64'h10, 64'h20, 1'b0, 4'd0); cycle();
    stall = 1'b1;
    drive_op(2'd3, 64'h2D, 64'h33, 1'b1, 4'd0); cycle();
    chk("t4_stall_cc", 64'(cc), 64'(3'b100));
    chk("t4_stall_val_e", val_e, 64'h30);
    stall = 1'b0; bubble = 1'b1;
    drive_op(2'd3, 64'h2D, 64'h33, 1'b1, 4'd0); cycle();
    chk("t4_bub_ov", 64'(out_valid), 64'(1'b0));
    chk("t4_bub_cc", 64'(cc), 64'(3'b100));
    bubble = 1'b0;

    // Bad condition code is sticky
    drive_op(2'd0, 64'd1, 64'd2, 1'b0, 4'd9);
    #1 chk("t5_cnd", 64'(cnd), 64'(1'b0));
    cycle();
    chk("t5_err", 64'(cc_err), 64'(1'b1));
    drive_idle(4'd0); cycle(); cycle();
    chk("t5_err_hold", 64'(cc_err), 64'(1'b1));

    // Same-cycle forwarding of fresh flags
    drive_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 4'd0); cycle();
    drive_op(2'd2, 64'hF0, 64'h0F, 1'b1, 4'd3);
`ifdef CC_FORWARD_EN
    #1 chk("t6_fwd_cnd", 64'(cnd), 64'(1'b1));
`else
    #1 chk("t6_nofwd_cnd", 64'(cnd), 64'(1'b0));
`endif
    cycle();
    chk("t6_cc", 64'(cc), 64'(3'b100));

    rst_n = 1'b0; drive_idle(4'd0); cycle();
    chk("t5_err_clr", 64'(cc_err), 64'(1'b0));
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 99) >= 3);
      stall  = ($urandom_range(0, 99) < 15);
      bubble = ($urandom_range(0, 99) < 15);
      fn = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
      a = rnd64();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = ~a;
        2:       b = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 63'($urandom)};
        default: b = rnd64();
      endcase
      if ($urandom_range(0, 99) < 70) drive_op(2'($urandom_range(0, 3)), a, b, 1'($urandom), fn);
      else drive_idle(fn);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
